song_sequencer: RTL and testbench

//  Plays a stored song by sequencing the single-voice tone generator (Sound) note by note.

---
 rtl/song_sequencer_pkg.sv | 26 ++
 rtl/song_sequencer_if.sv | 29 ++
 rtl/song_sequencer_timer.sv | 18 +
 rtl/song_sequencer.sv | 139 +++++++++++++
 tb/tb_song_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg: shared field widths, note-word layout and length clamp for the song sequencer
package song_sequencer_pkg;
    localparam int OCTAVE_BITS    = 3;
    localparam int NOTE_BITS      = 3;
    localparam int LENGTH_BITS    = 3;
    localparam int FULL_NOTE_BITS = 4;
    localparam int WORD_W         = 11;
    localparam int END_BIT        = 10;
    localparam int REST_BIT       = 9;
    localparam int OCT_LSB        = 6;
    localparam int NOTE_LSB       = 3;
    localparam int LEN_LSB        = 0;
    localparam logic [LENGTH_BITS-1:0] MAX_LENGTH = 3'd6;

    typedef struct packed {
        logic                   end_f;
        logic                   rest;
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
    } note_word_t;

    function automatic logic [LENGTH_BITS-1:0] clamp_length(input logic [LENGTH_BITS-1:0] l);
        return (l > MAX_LENGTH) ? MAX_LENGTH : l;
    endfunction
endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: UI commands, song ROM port and Sound generator port of the sequencer
interface song_sequencer_if #(parameter int PTR_W = 8, parameter int SONG_W = 2);
    import song_sequencer_pkg::*;
    logic                       start;
    logic                       pause;
    logic                       stop;
    logic [SONG_W-1:0]          song_sel;
    logic [FULL_NOTE_BITS-1:0]  tempo;
    logic [SONG_W+PTR_W-1:0]    rom_addr;
    logic [WORD_W-1:0]          rom_data;
    logic                       snd_en;
    logic [OCTAVE_BITS-1:0]     snd_octave;
    logic [NOTE_BITS-1:0]       snd_note;
    logic [LENGTH_BITS-1:0]     snd_length;
    logic [FULL_NOTE_BITS-1:0]  snd_full_note;
    logic                       snd_over;
    logic                       busy;
    logic                       done;
    logic [PTR_W-1:0]           note_idx;

    modport master (
        output start, pause, stop, song_sel, tempo, rom_data, snd_over,
        input  rom_addr, snd_en, snd_octave, snd_note, snd_length, snd_full_note, busy, done, note_idx
    );
    modport slave (
        input  start, pause, stop, song_sel, tempo, rom_data, snd_over,
        output rom_addr, snd_en, snd_octave, snd_note, snd_length, snd_full_note, busy, done, note_idx
    );
endinterface

// File: rtl/song_sequencer_timer.sv
// song_sequencer_timer: loadable down-counter shared by guard, rest and gap intervals
module song_sequencer_timer #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end

    assign o_expire = r_cnt <= W'(1);
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: fetches note words from the song ROM and drives the Sound generator note by note
module song_sequencer import song_sequencer_pkg::*; #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int PTR_W      = 8,
    parameter int SONG_W     = 2
) (
    input  logic clk,
    input  logic rst_n,
    song_sequencer_if.slave bus
);
    typedef enum logic [3:0] {IDLE, FETCH, WAIT_ROM, DECODE, GUARD, PLAY, REST, GAP, PAUSED, DONE} state_t;

    state_t                    r_state;
    note_word_t                r_word;
    logic [PTR_W-1:0]          r_ptr;
    logic [SONG_W-1:0]         r_song;
    logic [FULL_NOTE_BITS-1:0] r_tempo;
    logic                      r_pause_pend;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_en;
    logic [OCTAVE_BITS-1:0]    r_oct;
    logic [NOTE_BITS-1:0]      r_note;
    logic [LENGTH_BITS-1:0]    r_len;
    logic [FULL_NOTE_BITS-1:0] r_fn;
    logic [LENGTH_BITS-1:0]    w_len;
    logic                      w_is_rest;
    logic                      w_load;
    logic                      w_expire;
    logic [31:0]               w_rest;
    logic [31:0]               w_load_val;

    assign w_len      = clamp_length(r_word.length);
    assign w_is_rest  = r_word.rest || (r_word.note == 3'd7);
    assign w_rest     = (32'(r_tempo) * 32'(CLK_HZ)) >> w_len;
    assign w_load     = (r_state == DECODE && !r_word.end_f) || (r_state == PLAY && bus.snd_over) ||
                        (r_state == REST && w_expire);
    // Sound's over is stale for a couple of cycles after enable, so notes start with a 2-cycle guard
    assign w_load_val = (r_state == DECODE) ? (w_is_rest ? w_rest : 32'd2) : 32'(GAP_CYCLES);

    song_sequencer_timer #(.W(32)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_val    (w_load_val),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_ptr        <= '0;
            r_song       <= '0;
            r_tempo      <= '0;
            r_pause_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_en         <= 1'b0;
            r_oct        <= '0;
            r_note       <= '0;
            r_len        <= '0;
            r_fn         <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop) begin
                r_state      <= IDLE;
                r_en         <= 1'b0;
                r_ptr        <= '0;
                r_pause_pend <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                if (bus.pause && r_busy && r_state != PAUSED) r_pause_pend <= 1'b1;
                case (r_state)
                    IDLE, DONE: if (bus.start) begin
                        r_song  <= bus.song_sel;
                        r_tempo <= bus.tempo;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                    FETCH: r_state <= WAIT_ROM;
                    WAIT_ROM: begin
                        r_word  <= bus.rom_data;
                        r_state <= DECODE;
                    end
                    DECODE: if (r_word.end_f) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_pause_pend <= 1'b0;
                    end else if (w_is_rest) begin
                        r_state <= REST;
                    end else begin
                        r_oct   <= r_word.octave;
                        r_note  <= r_word.note;
                        r_len   <= w_len;
                        r_fn    <= r_tempo;
                        r_en    <= 1'b1;
                        r_state <= GUARD;
                    end
                    GUARD: if (w_expire) r_state <= PLAY;
                    PLAY: if (bus.snd_over) begin
                        r_en    <= 1'b0;
                        r_state <= GAP;
                    end
                    REST: if (w_expire) r_state <= GAP;
                    GAP: if (w_expire) begin
                        r_ptr <= r_ptr + PTR_W'(1);
                        if (&r_ptr) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_pause_pend <= 1'b0;
                        end else if (r_pause_pend || bus.pause) begin
                            r_state      <= PAUSED;
                            r_pause_pend <= 1'b0;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                    PAUSED: if (bus.start) r_state <= FETCH;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr      = {r_song, r_ptr};
    assign bus.note_idx      = r_ptr;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.snd_en        = r_en;
    assign bus.snd_octave    = r_oct;
    assign bus.snd_note      = r_note;
    assign bus.snd_length    = r_len;
    assign bus.snd_full_note = r_fn;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench with ROM and Sound models, expected note stream from song contents
module tb_song_sequencer;
    import song_sequencer_pkg::*;
    localparam int CLK_HZ = 1000;
    localparam int GAP    = 4;
    localparam int PTR_W  = 8;
    localparam int SONG_W = 2;
    localparam int WORDS  = 1 << PTR_W;

    typedef struct packed {int kind; int idx; int oct; int note; int len; int fn; int cnt;} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] mem [1024];
    ev_t sb[$];
    int total = 0;
    int bad = 0;
    int sc = 0;
    int dur = 3;
    int cur = -1;
    int cnt = 0;
    bit saw, prev_en, prev_done;

    always #5 clk = ~clk;

    song_sequencer_if #(.PTR_W(PTR_W), .SONG_W(SONG_W)) bus();

    song_sequencer #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(GAP), .PTR_W(PTR_W), .SONG_W(SONG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    // Sound model: over is stale-high on the first enabled cycle, then rises after dur cycles
    always @(posedge clk) begin
        if (!bus.snd_en) begin
            sc  <= 0;
            dur <= int'($urandom_range(3, 12));
        end else sc <= sc + 1;
    end
    assign bus.snd_over = bus.snd_en && (sc == 0 || sc >= dur);

    function automatic ev_t mk(int k, int i, int o, int n, int l, int f, int c);
        ev_t e;
        e.kind = k; e.idx = i; e.oct = o; e.note = n; e.len = l; e.fn = f; e.cnt = c;
        return e;
    endfunction

    function automatic logic [10:0] word(int e, int r, int o, int n, int l);
        return {1'(e), 1'(r), 3'(o), 3'(n), 3'(l)};
    endfunction

    task automatic check(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic obs(input ev_t o);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d idx=%0d oct=%0d note=%0d len=%0d fn=%0d cnt=%0d, required none",
                     o.kind, o.idx, o.oct, o.note, o.len, o.fn, o.cnt);
        end else begin
            e = sb.pop_front();
            if (e != o) begin
                bad++;
                $display("FAIL event: got kind=%0d idx=%0d oct=%0d note=%0d len=%0d fn=%0d cnt=%0d, required kind=%0d idx=%0d oct=%0d note=%0d len=%0d fn=%0d cnt=%0d",
                         o.kind, o.idx, o.oct, o.note, o.len, o.fn, o.cnt, e.kind, e.idx, e.oct, e.note, e.len, e.fn, e.cnt);
            end
        end
    endtask

    // Expected stream: kind 0 = note start, 1 = silent word (cycles at that pointer), 2 = done
    task automatic model(input int s, input int t);
        for (int i = 0; i < WORDS; i++) begin
            logic [10:0] w;
            int len;
            w = mem[s * WORDS + i];
            len = (w[2:0] > 3'd6) ? 6 : int'(w[2:0]);
            if (w[10]) begin
                sb.push_back(mk(1, i, 0, 0, 0, 0, 3));
                sb.push_back(mk(2, 0, 0, 0, 0, 0, 0));
                return;
            end
            if (w[9] || w[5:3] == 3'd7) sb.push_back(mk(1, i, 0, 0, 0, 0, 3 + ((t * CLK_HZ) >> len) + GAP));
            else sb.push_back(mk(0, i, int'(w[8:6]), int'(w[5:3]), len, t, 0));
        end
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        if (!rst_n) cur = -1;
        else begin
            if (cur >= 0 && (!bus.busy || int'(bus.note_idx) != cur)) begin
                if (!saw && (bus.busy || bus.done)) obs(mk(1, cur, 0, 0, 0, 0, cnt));
                cur = -1;
            end
            if (bus.busy && cur < 0) begin
                cur = int'(bus.note_idx);
                cnt = 0;
                saw = 1'b0;
            end
            if (bus.busy) begin
                cnt++;
                saw |= bus.snd_en;
            end
            if (bus.snd_en && !prev_en)
                obs(mk(0, int'(bus.note_idx), int'(bus.snd_octave), int'(bus.snd_note), int'(bus.snd_length),
                       int'(bus.snd_full_note), 0));
            if (bus.done) begin
                check("busy_with_done", longint'(bus.busy), 0);
                check("done_one_cycle", longint'(prev_done), 0);
                obs(mk(2, 0, 0, 0, 0, 0, 0));
            end
        end
        prev_en   = bus.snd_en;
        prev_done = bus.done;
    end

    task automatic drive(input logic st, input logic pa, input logic sp);
        bus.start = st;
        bus.pause = pa;
        bus.stop  = sp;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // mode 0: done pulse; 1: note k sounding; 2: busy and silent at pointer k
    task automatic wait_for(input string nm, input int mode, input int k, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (mode == 0) ? bus.done :
                 (mode == 1) ? (bus.snd_en && int'(bus.note_idx) == k) :
                               (bus.busy && !bus.snd_en && int'(bus.note_idx) == k);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: timed out after %0d cycles, required event never seen", nm, budget);
        end
    endtask

    task automatic run_song(input string nm, input int s, input int t, input int budget);
        model(s, t);
        bus.song_sel = SONG_W'(s);
        bus.tempo    = FULL_NOTE_BITS'(t);
        drive(1'b1, 1'b0, 1'b0);
        wait_for(nm, 0, 0, budget);
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_drained"}, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_en"}, bus.snd_en, 0);
        check({nm, "_busy"}, bus.busy, 0);
        check({nm, "_done"}, bus.done, 0);
        check({nm, "_idx"}, bus.note_idx, 0);
        check({nm, "_addr"}, bus.rom_addr, 0);
        check({nm, "_oct"}, bus.snd_octave, 0);
        check({nm, "_note"}, bus.snd_note, 0);
        check({nm, "_len"}, bus.snd_length, 0);
        check({nm, "_fn"}, bus.snd_full_note, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        bus.song_sel = '0; bus.tempo = '0;
        for (int i = 0; i < 1024; i++) mem[i] = word(1, 0, 0, 0, 0);
        mem[0]   = word(0, 0, 4, 0, 2);
        mem[256] = word(0, 1, 0, 0, 1);
        mem[257] = word(0, 0, 5, 2, 3);
        mem[512] = word(0, 0, 4, 1, 4);
        mem[513] = word(0, 0, 3, 4, 5);
        mem[514] = word(0, 0, 5, 6, 2);
        mem[768] = word(0, 0, 2, 3, 7);
        mem[769] = word(0, 0, 1, 7, 5);
        for (int i = 770; i < 1024; i++) begin
            int r, n;
            r = ($urandom % 4 == 0) ? 1 : 0;
            n = int'($urandom % 8);
            mem[i] = word(0, r, int'($urandom % 8), n, (r == 1 || n == 7) ? int'($urandom_range(3, 7)) : int'($urandom % 8));
        end

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        run_song("single_note", 0, 2, 500);
        run_song("timed_rest", 1, 2, 3000);

        model(2, 3);
        bus.song_sel = 2'd2;
        bus.tempo    = 4'd3;
        drive(1'b1, 1'b0, 1'b0);
        wait_for("pause_note0", 1, 0, 200);
        drive(1'b0, 1'b1, 1'b0);
        wait_for("pause_reach", 2, 1, 200);
        repeat (20) @(posedge clk);
        #1;
        check("paused_en", bus.snd_en, 0);
        check("paused_busy", bus.busy, 1);
        check("paused_idx", bus.note_idx, 1);
        drive(1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("paused_ignore_pause_idx", bus.note_idx, 1);
        check("paused_ignore_pause_en", bus.snd_en, 0);
        drive(1'b1, 1'b1, 1'b0);
        wait_for("resume_done", 0, 0, 500);
        repeat (2) @(posedge clk);
        #1;
        check("resume_drained", sb.size(), 0);

        model(2, 2);
        bus.tempo = 4'd2;
        drive(1'b1, 1'b0, 1'b0);
        wait_for("stop_note1", 1, 1, 300);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1);
        check("stop_en", bus.snd_en, 0);
        check("stop_busy", bus.busy, 0);
        check("stop_idx", bus.note_idx, 0);
        check("stop_done", bus.done, 0);
        sb.delete();
        repeat (30) @(posedge clk);
        #1;
        check("stop_stays_idle", bus.busy, 0);
        run_song("replay", 2, 2, 500);

        drive(1'b1, 1'b0, 1'b1);
        check("start_stop_busy", bus.busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("start_stop_idle", bus.busy, 0);
        check("start_stop_en", bus.snd_en, 0);

        model(2, 2);
        drive(1'b1, 1'b0, 1'b0);
        wait_for("rst_note0", 1, 0, 200);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_song("full_song", 3, 1, 40000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
